// File: rtl/riscv_imm_pkg.sv
// Shared RV32I immediate-format codes and the instruction-bit masks each format occupies.
package riscv_imm_pkg;

  typedef enum logic [2:0] {
    IMM_U   = 3'b000,
    IMM_J   = 3'b001,
    IMM_S   = 3'b010,
    IMM_B   = 3'b011,
    IMM_I   = 3'b100,
    IMM_ISH = 3'b101,
    IMM_IU  = 3'b110,
    IMM_INV = 3'b111
  } imm_sel_e;

  localparam logic [31:0] MASK_U   = 32'hFFFF_F000;
  localparam logic [31:0] MASK_J   = 32'hFFFF_F000;
  localparam logic [31:0] MASK_S   = 32'hFE00_0F80;
  localparam logic [31:0] MASK_B   = 32'hFE00_0F80;
  localparam logic [31:0] MASK_I   = 32'hFFF0_0000;
  localparam logic [31:0] MASK_ISH = 32'h01F0_0000;

  // True when v[31:msb] are all equal, i.e. v is a sign extension of v[msb:0].
  function automatic logic sext_ok(input logic [31:0] v, input int unsigned msb);
    logic [31:0] m;
    m = '1 << msb;
    return ((v & m) == m) || ((v & m) == '0);
  endfunction

endpackage

// File: rtl/imm_field_packer.sv
// Combinational packer: clears the format's immediate bits in the base word, ORs the
// scattered immediate in, and flags immediates the format cannot represent.
module imm_field_packer
  import riscv_imm_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_base,
  output logic [31:0] o_instr,
  output logic        o_err
);

  imm_sel_e    w_sel;
  logic [31:0] w_mask;
  logic [31:0] w_field;

  assign w_sel = imm_sel_e'(i_fmt);

  always_comb begin
    w_mask  = '0;
    w_field = '0;
    o_err   = 1'b0;
    case (w_sel)
      IMM_U: begin
        w_mask  = MASK_U;
        w_field = {i_imm[31:12], 12'b0};
        o_err   = |i_imm[11:0];
      end
      IMM_J: begin
        w_mask  = MASK_J;
        w_field = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'b0};
        o_err   = i_imm[0] | ~sext_ok(i_imm, 20);
      end
      IMM_S: begin
        w_mask  = MASK_S;
        w_field = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
        o_err   = ~sext_ok(i_imm, 11);
      end
      IMM_B: begin
        w_mask  = MASK_B;
        w_field = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
        o_err   = i_imm[0] | ~sext_ok(i_imm, 12);
      end
      IMM_I: begin
        w_mask  = MASK_I;
        w_field = {i_imm[11:0], 20'b0};
        o_err   = ~sext_ok(i_imm, 11);
      end
      IMM_ISH: begin
        // funct7 in [31:25] is left to the base word
        w_mask  = MASK_ISH;
        w_field = {7'b0, i_imm[4:0], 20'b0};
        o_err   = |i_imm[31:5];
      end
      IMM_IU: begin
        w_mask  = MASK_I;
        w_field = {i_imm[11:0], 20'b0};
        o_err   = |i_imm[31:12];
      end
      default: begin
        o_err = 1'b1;
      end
    endcase
    o_instr = (i_base & ~w_mask) | w_field;
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready pipeline around imm_field_packer, with delivered-beat and
// error-beat counters.
module imm_encoder
  import riscv_imm_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter bit          CHECK_RANGE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  logic [31:0]      w_instr;
  logic             w_err;
  logic             w_b_load;
  logic             w_fire;

  logic             r_a_valid;
  logic [31:0]      r_a_instr;
  logic             r_a_err;
  logic             r_b_valid;
  logic [31:0]      r_b_instr;
  logic             r_b_err;
  logic [CNT_W-1:0] r_enc_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  imm_field_packer u_packer (
    .i_fmt   (in_fmt),
    .i_imm   (in_imm),
    .i_base  (in_base),
    .o_instr (w_instr),
    .o_err   (w_err)
  );

  assign w_b_load = ~r_b_valid | out_ready;
  assign in_ready = ~r_a_valid | w_b_load;
  assign w_fire   = r_b_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_instr <= '0;
      r_a_err   <= 1'b0;
      r_b_valid <= 1'b0;
      r_b_instr <= '0;
      r_b_err   <= 1'b0;
      r_enc_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (in_ready) begin
        r_a_valid <= in_valid;
        if (in_valid) begin
          r_a_instr <= w_instr;
          r_a_err   <= w_err;
        end
      end
      if (w_b_load) begin
        r_b_valid <= r_a_valid;
        if (r_a_valid) begin
          r_b_instr <= r_a_instr;
          r_b_err   <= r_a_err;
        end
      end
      // The raw range flag still feeds err_count when out_err is masked off
      if (w_fire) begin
        r_enc_cnt <= r_enc_cnt + CNT_W'(1);
        if (r_b_err) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid = r_b_valid;
  assign out_instr = r_b_instr;
  assign out_err   = CHECK_RANGE ? r_b_err : 1'b0;
  assign enc_count = r_enc_cnt;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized and directed bench for imm_encoder against an arithmetic reference model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  in_fmt = '0;
  logic [31:0] in_imm = '0;
  logic [31:0] in_base = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  imm_encoder #(.CNT_W(16), .CHECK_RANGE(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_imm    (in_imm),
    .in_base   (in_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_enc = '0;
  logic [15:0] m_err = '0;
  logic        stop_rdy = 1'b0;

  logic [31:0] bnd [16] = '{32'h7FF, 32'h800, 32'hFFFFF800, 32'hFFFFF7FF, 32'hFFE, 32'h1000,
                            32'hFFFFF000, 32'hFFFFEFFF, 32'hFFFFE, 32'h100000, 32'hFFF00000,
                            32'hFFEFFFFF, 32'd31, 32'd32, 32'd4095, 32'd4096};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Copy imm[hi:lo] into w starting at bit dst
  function automatic logic [31:0] put(input logic [31:0] w, input logic [31:0] imm,
                                      input int hi, input int lo, input int dst);
    for (int i = lo; i <= hi; i++) w[dst + i - lo] = imm[i];
    return w;
  endfunction

  function automatic exp_t model(input logic [2:0] f, input logic [31:0] imm, input logic [31:0] base);
    exp_t        e;
    longint      s;
    logic [31:0] w;
    s = longint'($signed(imm));
    e.fmt = f;
    e.imm = imm;
    case (f)
      3'd0: begin
        w = (base & 32'h00000FFF) | (imm & 32'hFFFFF000);
        e.err = (imm % 4096) != 0;
      end
      3'd1: begin
        w = base & ~32'hFFFFF000;
        w = put(w, imm, 20, 20, 31);
        w = put(w, imm, 10, 1, 21);
        w = put(w, imm, 11, 11, 20);
        w = put(w, imm, 19, 12, 12);
        e.err = (imm % 2 != 0) || s < -1048576 || s > 1048575;
      end
      3'd2: begin
        w = base & ~32'hFE000F80;
        w = put(w, imm, 11, 5, 25);
        w = put(w, imm, 4, 0, 7);
        e.err = s < -2048 || s > 2047;
      end
      3'd3: begin
        w = base & ~32'hFE000F80;
        w = put(w, imm, 12, 12, 31);
        w = put(w, imm, 10, 5, 25);
        w = put(w, imm, 4, 1, 8);
        w = put(w, imm, 11, 11, 7);
        e.err = (imm % 2 != 0) || s < -4096 || s > 4095;
      end
      3'd4: begin
        w = put(base & ~32'hFFF00000, imm, 11, 0, 20);
        e.err = s < -2048 || s > 2047;
      end
      3'd5: begin
        w = put(base & ~32'h01F00000, imm, 4, 0, 20);
        e.err = imm > 31;
      end
      3'd6: begin
        w = put(base & ~32'hFFF00000, imm, 11, 0, 20);
        e.err = imm > 4095;
      end
      default: begin
        w = base;
        e.err = 1'b1;
      end
    endcase
    e.instr = w;
    return e;
  endfunction

  // Standard RV32I immediate decode used for the round-trip check
  function automatic logic [31:0] decode(input logic [2:0] f, input logic [31:0] x);
    case (f)
      3'd0:    return {x[31:12], 12'h0};
      3'd1:    return {{12{x[31]}}, x[19:12], x[20], x[30:21], 1'b0};
      3'd2:    return {{20{x[31]}}, x[31:25], x[11:7]};
      3'd3:    return {{20{x[31]}}, x[7], x[30:25], x[11:8], 1'b0};
      3'd4:    return {{20{x[31]}}, x[31:20]};
      3'd5:    return {27'b0, x[24:20]};
      3'd6:    return {20'b0, x[31:20]};
      default: return x;
    endcase
  endfunction

  function automatic logic [31:0] rand_imm();
    case ($urandom % 4)
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 64)) - 32'd32;
      2:       return bnd[$urandom % 16];
      default: return $urandom << 12;
    endcase
  endfunction

  // Compare process: all outputs checked on every cycle out of reset
  logic        p_hold = 1'b0;
  logic [31:0] p_instr;
  logic        p_err;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      m_enc = '0;
      m_err = '0;
      p_hold = 1'b0;
    end else begin
      chk("enc_count", 32'(enc_count), 32'(m_enc));
      chk("err_count", 32'(err_count), 32'(m_err));
      if (p_hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_instr", out_instr, p_instr);
        chk("hold_err", 32'(out_err), 32'(p_err));
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          total = total + 1;
          bad = bad + 1;
          $display("FAIL spurious_beat got=out_valid=1 want=no pending beat at %0t", $time);
        end else begin
          e = q[0];
          chk("out_instr", out_instr, e.instr);
          chk("out_err", 32'(out_err), 32'(e.err));
          if (out_ready) begin
            void'(q.pop_front());
            if (!e.err && e.fmt != 3'd7) chk("roundtrip", decode(e.fmt, out_instr), e.imm);
            m_enc = m_enc + 16'd1;
            if (e.err) m_err = m_err + 16'd1;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_fmt, in_imm, in_base));
      p_hold  = out_valid && !out_ready;
      p_instr = out_instr;
      p_err   = out_err;
    end
  end

  // Entered and left at posedge+1; bounded wait for acceptance
  task automatic send(input logic [2:0] f, input logic [31:0] imm, input logic [31:0] base);
    logic ok;
    in_valid = 1'b1;
    in_fmt   = f;
    in_imm   = imm;
    in_base  = base;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) return;
    end
    total = total + 1;
    bad = bad + 1;
    $display("FAIL send_timeout got=in_ready stuck 0 want=accept within 200 cycles");
  endtask

  // Single beat into an empty pipeline with out_ready=1: checks the two-cycle latency
  task automatic beat_direct(input string nm, input logic [2:0] f, input logic [31:0] imm,
                             input logic [31:0] base, input logic [31:0] xi, input logic xe);
    in_valid = 1'b1;
    in_fmt   = f;
    in_imm   = imm;
    in_base  = base;
    @(negedge clk);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_lat1_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_lat2_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_instr"}, out_instr, xi);
    chk({nm, "_err"}, 32'(out_err), 32'(xe));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0 && !out_valid) return;
    end
    total = total + 1;
    bad = bad + 1;
    $display("FAIL %s_drain_timeout got=%0d pending want=0", nm, q.size());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    exp_t        e;
    logic [15:0] err_before;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_enc_count", 32'(enc_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    e = model(3'd4, 32'hFFFFFFFF, 32'h00000513);
    chk("model_I", {e.instr[31:1], e.instr[0] ^ e.err}, 32'hFFF00513);
    e = model(3'd3, 32'hFFFFFFFC, 32'h00000063);
    chk("model_B", e.instr, 32'hFE000EE3);
    e = model(3'd3, 32'h00000003, 32'h00000063);
    chk("model_B_err", 32'(e.err), 32'd1);
    e = model(3'd1, 32'h00000800, 32'h0000006F);
    chk("model_J", e.instr, 32'h0010006F);
    e = model(3'd2, 32'h00000800, 32'h00000023);
    chk("model_S", {e.instr[31:1], e.err}, 32'h80000023);

    @(posedge clk);
    #1;
    beat_direct("I", 3'd4, 32'hFFFFFFFF, 32'h00000513, 32'hFFF00513, 1'b0);
    beat_direct("B", 3'd3, 32'hFFFFFFFC, 32'h00000063, 32'hFE000EE3, 1'b0);
    beat_direct("B_odd", 3'd3, 32'h00000003, 32'h00000063, 32'h00000163, 1'b1);
    beat_direct("J", 3'd1, 32'h00000800, 32'h0000006F, 32'h0010006F, 1'b0);
    err_before = m_err;
    beat_direct("S", 3'd2, 32'h00000800, 32'h00000023, 32'h80000023, 1'b1);
    @(negedge clk);
    chk("S_err_count_inc", 32'(err_count), 32'(err_before) + 32'd1);
    @(posedge clk);
    #1;

    // Backpressure: five back-to-back beats against a stalled consumer
    do_reset();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(3'd4, 32'(i * 16 + 1), 32'h13 + 32'(i << 7));
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_held", 32'(in_ready), 32'd0);
        chk("bp_out_valid_held", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("bp");
    @(negedge clk);
    chk("bp_enc_count", 32'(enc_count), 32'd5);
    @(posedge clk);
    #1;

    // Reset with both stages full and a handshake pending on each side
    out_ready = 1'b0;
    send(3'd0, 32'h12345000, 32'h000000B7);
    send(3'd5, 32'd7, 32'h40005013);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_enc_count", 32'(enc_count), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    beat_direct("post_rst", 3'd6, 32'h00000ABC, 32'h00003013, 32'hABC03013, 1'b0);

    // Randomized traffic with random consumer stalls
    stop_rdy = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          int unsigned idle;
          idle = $urandom % 3;
          in_valid = 1'b0;
          repeat (idle) begin
            @(posedge clk);
            #1;
          end
          send(3'($urandom_range(0, 7)), rand_imm(), $urandom);
        end
        in_valid = 1'b0;
        stop_rdy = 1'b1;
      end
      begin
        while (!stop_rdy) begin
          out_ready = ($urandom % 4) != 0;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
